fir: RTL and testbench

- 10-tap direct-form FIR filter on an unsigned 32-bit sample stream.
- Accepts one sample per clock and produces one registered filtered output per clock.
- Fixed symmetric integer coefficients.
- Used as a self-contained datapath stage; no handshake, so every clock edge is a sample.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_delay_line.sv | 29 ++
 rtl/fir.sv | 61 ++++++
 tb/tb_fir.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the 10-tap symmetric FIR filter.
// Optional build macro FIR_SAT_EN (saturating output) is consumed in fir.sv.
package fir_pkg;

    localparam int DATA_W = 32;
    localparam int NTAPS  = 10;
    // Must be at least DATA_W+5 so that 30 * (2^DATA_W - 1) cannot overflow.
    localparam int ACC_W  = 40;

    // h[0] weights the newest sample; the DC gain is 30.
    localparam int unsigned FIR_COEF [NTAPS] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1};

    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/fir_delay_line.sv
// Sample history for the FIR: a DEPTH-stage shift register, stage 0 newest.
// All stages are visible to the parent so it can form the tap products.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int DEPTH = NTAPS - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  sample_t             i_x,
    output sample_t [DEPTH-1:0] o_d
);

    sample_t [DEPTH-1:0] r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d <= '0;
        end else begin
            r_d[0] <= i_x;
            for (int k = 1; k < DEPTH; k++) begin
                r_d[k] <= r_d[k-1];
            end
        end
    end

    assign o_d = r_d;

endmodule

// File: rtl/fir.sv
// 10-tap direct-form FIR, one sample in and one registered result out per clock.
// Build macro FIR_SAT_EN: clamp the result to all ones instead of wrapping modulo 2^DATA_W.
module fir
    import fir_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  sample_t x,
    output sample_t y
);

    sample_t [NTAPS-2:0] w_d;
    sample_t [NTAPS-1:0] w_tap;
    acc_t    [NTAPS-1:0] w_prod;
    acc_t                w_sum;
    sample_t             w_y_next;
    sample_t             r_y;

    fir_delay_line #(.DEPTH(NTAPS - 1)) u_dly (
        .clk (clk),
        .rst (rst),
        .i_x (x),
        .o_d (w_d)
    );

    // Tap 0 is the live input, so the result reflects x with one clock of latency.
    assign w_tap[0] = x;

    for (genvar k = 1; k < NTAPS; k++) begin : g_tap
        assign w_tap[k] = w_d[k-1];
    end

    // Constant-coefficient products; synthesis reduces these to shift/add.
    for (genvar k = 0; k < NTAPS; k++) begin : g_prod
        assign w_prod[k] = acc_t'(w_tap[k]) * acc_t'(FIR_COEF[k]);
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_sum = w_sum + w_prod[k];
        end
    end

`ifdef FIR_SAT_EN
    assign w_y_next = (w_sum > acc_t'({DATA_W{1'b1}})) ? '1 : w_sum[DATA_W-1:0];
`else
    assign w_y_next = w_sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= '0;
        end else begin
            r_y <= w_y_next;
        end
    end

    assign y = r_y;

endmodule

// File: tb/tb_fir.sv
// Randomized and directed bench for fir against a queue-based convolution model.
// Honors FIR_SAT_EN when the macro is defined for the whole build.
module tb_fir;

    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;

    int n_tests;
    int n_fail;
    int cyc;

    // Model state: past accepted samples, newest first; missing entries count as zero.
    longint unsigned hist[$];
    logic [31:0]     exp_y;
    int unsigned     coef [10] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1};

    logic [31:0] imp_lit  [12] = '{1, 2, 3, 4, 5, 5, 4, 3, 2, 1, 0, 0};
    logic [31:0] ramp_lit [12] = '{1, 3, 6, 10, 15, 20, 24, 27, 29, 30, 30, 30};

    fir dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_out(input longint unsigned v);
        longint unsigned acc;
        acc = coef[0] * v;
        for (int k = 1; k < 10; k++) begin
            if (k - 1 < hist.size()) acc += coef[k] * hist[k-1];
        end
`ifdef FIR_SAT_EN
        return (acc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : acc[31:0];
`else
        return acc[31:0];
`endif
    endfunction

    task automatic step(input logic r, input logic [31:0] v);
        @(negedge clk);
        rst = r;
        x   = v;
        @(posedge clk);
        cyc++;
        if (r) begin
            hist.delete();
            exp_y = '0;
        end else begin
            exp_y = model_out(longint'(v));
            hist.push_front(longint'(v));
            if (hist.size() > 9) void'(hist.pop_back());
        end
        #1;
        n_tests++;
        if (y !== exp_y) begin
            n_fail++;
            $display("FAIL y_vs_model cycle %0d: got %h expected %h", cyc, y, exp_y);
        end
    endtask

    // Directed literal: pins both the DUT and the model.
    task automatic lit(input string nm, input logic [31:0] e);
        n_tests++;
        if (y !== e || exp_y !== e) begin
            n_fail++;
            $display("FAIL %s cycle %0d: dut %h model %h expected %h", nm, cyc, y, exp_y, e);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        exp_y   = '0;
        rst     = 1'b1;
        x       = 32'd5;

        // Reset dominates x
        step(1'b1, 32'd5);
        step(1'b1, 32'd5);
        lit("reset", 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0);
            lit("reset_idle", 32'd0);
        end

        // Impulse response
        step(1'b0, 32'd1);
        lit("impulse", imp_lit[0]);
        for (int i = 1; i < 12; i++) begin
            step(1'b0, 32'd0);
            lit("impulse", imp_lit[i]);
        end

        // Step response from reset, then DC levels and mixed history
        step(1'b1, 32'd0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'd1);
            lit("ramp", ramp_lit[i]);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 32'd2);
        lit("dc2", 32'd60);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd3);
        lit("mix3", 32'd75);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd4);
        lit("mix4", 32'd105);

        // Large value
        for (int i = 0; i < 10; i++) step(1'b0, 32'd1116988);
        lit("large", 32'd33509640);

        // Overflow
        for (int i = 0; i < 10; i++) step(1'b0, 32'hFFFF_FFFF);
`ifdef FIR_SAT_EN
        lit("overflow", 32'hFFFF_FFFF);
`else
        lit("overflow", 32'hFFFF_FFE2);
`endif

        // Mid-stream reset discards history
        step(1'b1, 32'hFFFF_FFFF);
        lit("mid_reset", 32'd0);
        step(1'b0, 32'd1);
        lit("impulse2", imp_lit[0]);
        for (int i = 1; i < 12; i++) begin
            step(1'b0, 32'd0);
            lit("impulse2", imp_lit[i]);
        end

        // Randomized stream with occasional resets and a mix of magnitudes
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic [31:0] v;
            r = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 15);
                1:       v = $urandom_range(0, 32'h00FF_FFFF);
                2:       v = 32'hFFFF_FFFF - $urandom_range(0, 255);
                default: v = $urandom;
            endcase
            step(r, v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
